// File: rtl/motoro3_commutator.sv
// Six-step commutation sequencer for a 3-phase bridge. Every step change and every start-up
// begins with a dead-time window in which all phases are off.
module motoro3_commutator #(
  parameter int unsigned DEAD_CYCLES = 20,
  parameter int unsigned CW          = 8
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       run,
  input  logic       dir,
  input  logic       stepReq,
  input  logic       pwm,
  output logic [2:0] mosEnable,
  output logic [2:0] h1_L0,
  output logic [2:0] step,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StDead, StDrive} state_e;

  localparam logic [CW-1:0] Reload = CW'(DEAD_CYCLES - 1);

  state_e        stateQ, stateD;
  logic [2:0]    stepQ, stepD;
  logic [CW-1:0] cntQ, cntD;
  logic          pendQ, pendD;
  logic [2:0]    enQ, enD, selQ, selD;
  logic          busyQ, busyD;

  // Out-of-range steps recover to 0 on the next advance.
  function automatic logic [2:0] nextStep(input logic [2:0] s, input logic d);
    if (s > 3'd5) return 3'd0;
    if (d) return (s == 3'd5) ? 3'd0 : s + 3'd1;
    return (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

  always_comb begin
    stateD = stateQ;
    stepD  = stepQ;
    cntD   = cntQ;
    pendD  = pendQ;
    if (!run) begin
      stateD = StIdle;
      pendD  = 1'b0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          stateD = StDead;
          cntD   = Reload;
        end
        StDead: begin
          if (cntQ == '0) begin
            // A request landing on the final dead cycle counts as pending.
            if (pendQ || stepReq) begin
              stepD = nextStep(stepQ, dir);
              pendD = 1'b0;
              cntD  = Reload;
            end else begin
              stateD = StDrive;
            end
          end else begin
            cntD  = cntQ - CW'(1);
            pendD = pendQ | stepReq;
          end
        end
        StDrive: begin
          if (stepReq) begin
            stepD  = nextStep(stepQ, dir);
            stateD = StDead;
            cntD   = Reload;
          end
        end
        default: stateD = StIdle;
      endcase
    end
  end

  // Outputs decode from next state so they are registered with no extra latency.
  always_comb begin
    enD   = 3'b000;
    selD  = 3'b000;
    busyD = (stateD == StDead);
    if (stateD == StDrive) begin
      case (stepD)
        3'd0: begin enD = 3'b011; selD = {2'b00, pwm};       end
        3'd1: begin enD = 3'b101; selD = {2'b00, pwm};       end
        3'd2: begin enD = 3'b110; selD = {1'b0, pwm, 1'b0};  end
        3'd3: begin enD = 3'b011; selD = {1'b0, pwm, 1'b0};  end
        3'd4: begin enD = 3'b101; selD = {pwm, 2'b00};       end
        3'd5: begin enD = 3'b110; selD = {pwm, 2'b00};       end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      stateQ <= StIdle;
      stepQ  <= 3'd0;
      cntQ   <= '0;
      pendQ  <= 1'b0;
      enQ    <= 3'b000;
      selQ   <= 3'b000;
      busyQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      stepQ  <= stepD;
      cntQ   <= cntD;
      pendQ  <= pendD;
      enQ    <= enD;
      selQ   <= selD;
      busyQ  <= busyD;
    end
  end

  assign mosEnable = enQ;
  assign h1_L0     = selQ;
  assign step      = stepQ;
  assign busy      = busyQ;

endmodule

// File: tb/tb_motoro3_commutator.sv
// Directed bench for motoro3_commutator: start-up, sweeps, wrap, pending request, abort, reset.
module tb_motoro3_commutator;

  logic       clk = 1'b0;
  logic       nRst, run, dir, stepReq, pwm;
  logic [2:0] mosEnable, h1_L0, step;
  logic       busy;
  int         nVec = 0;
  int         nFail = 0;

  // Expected drive pattern per step with pwm=1.
  logic [2:0] enTab  [6] = '{3'b011, 3'b101, 3'b110, 3'b011, 3'b101, 3'b110};
  logic [2:0] selTab [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};

  motoro3_commutator #(.DEAD_CYCLES(20), .CW(8)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .run       (run),
    .dir       (dir),
    .stepReq   (stepReq),
    .pwm       (pwm),
    .mosEnable (mosEnable),
    .h1_L0     (h1_L0),
    .step      (step),
    .busy      (busy)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One stepReq from DRIVE: 20 dead clocks, then the new step is driven.
  task automatic doStep(input logic d, input logic [2:0] s);
    dir = d;
    stepReq = 1'b1;
    cyc(1);
    stepReq = 1'b0;
    chk("stepAdv", step, s);
    chk("deadOffFirst", mosEnable, 3'b000);
    chk("deadBusyFirst", {2'b00, busy}, 3'b001);
    cyc(19);
    chk("deadOffLast", mosEnable, 3'b000);
    chk("deadBusyLast", {2'b00, busy}, 3'b001);
    cyc(1);
    chk("drvBusy", {2'b00, busy}, 3'b000);
    chk("drvEn", mosEnable, enTab[s]);
    chk("drvSel", h1_L0, selTab[s]);
    cyc(29);
  endtask

  always @(negedge clk) begin
    nVec++;
    assert (((h1_L0 & ~mosEnable) == 3'b000) && ($countones(h1_L0) <= 1) &&
            (mosEnable != 3'b111)) else begin
      nFail++;
      $error("FAIL invariant: observed en=%b sel=%b expected legal pair", mosEnable, h1_L0);
    end
  end

  initial begin
    nRst = 1'b0; run = 1'b0; dir = 1'b1; stepReq = 1'b0; pwm = 1'b1;
    cyc(2);
    chk("rstEn", mosEnable, 3'b000);
    chk("rstSel", h1_L0, 3'b000);
    chk("rstStep", step, 3'd0);
    chk("rstBusy", {2'b00, busy}, 3'b000);
    nRst = 1'b1;
    cyc(2);
    chk("idleBusy", {2'b00, busy}, 3'b000);

    // Start-up: exactly 20 busy clocks, then step 0.
    run = 1'b1;
    cyc(1);
    for (int i = 0; i < 20; i++) begin
      chk("startBusy", {2'b00, busy}, 3'b001);
      chk("startOff", mosEnable, 3'b000);
      cyc(1);
    end
    chk("startDone", {2'b00, busy}, 3'b000);
    chk("startEn", mosEnable, 3'b011);
    chk("startSel", h1_L0, 3'b001);
    chk("startStep", step, 3'd0);
    pwm = 1'b0;
    chk("pwmHold", h1_L0, 3'b001);
    cyc(1);
    chk("pwmLow", h1_L0, 3'b000);
    pwm = 1'b1;
    cyc(1);
    chk("pwmHigh", h1_L0, 3'b001);
    cyc(20);

    // Forward sweep 1,2,3,4,5,0,1.
    for (int i = 0; i < 7; i++) doStep(1'b1, 3'((i + 1) % 6));

    // Reverse: 1 -> 0 -> 5 (wrap).
    doStep(1'b0, 3'd0);
    doStep(1'b0, 3'd5);
    pwm = 1'b0;
    cyc(1);
    chk("revPwmLow", h1_L0, 3'b000);
    chk("revEn", mosEnable, 3'b110);
    pwm = 1'b1;
    cyc(1);
    chk("revPwmHigh", h1_L0, 3'b100);

    // Pending: two requests during dead time give one extra advance.
    dir = 1'b1;
    stepReq = 1'b1;
    cyc(1);
    stepReq = 1'b0;
    chk("pendFirst", step, 3'd0);
    cyc(4);
    stepReq = 1'b1;
    cyc(1);
    stepReq = 1'b0;
    cyc(4);
    stepReq = 1'b1;
    cyc(1);
    stepReq = 1'b0;
    cyc(9);
    chk("pendWin1Busy", {2'b00, busy}, 3'b001);
    chk("pendWin1Step", step, 3'd0);
    cyc(1);
    chk("pendAdvStep", step, 3'd1);
    chk("pendWin2Busy", {2'b00, busy}, 3'b001);
    chk("pendWin2Off", mosEnable, 3'b000);
    cyc(19);
    chk("pendWin2Last", {2'b00, busy}, 3'b001);
    cyc(1);
    chk("pendDrvBusy", {2'b00, busy}, 3'b000);
    chk("pendDrvStep", step, 3'd1);
    chk("pendDrvEn", mosEnable, 3'b101);
    cyc(5);

    // Abort: run=0 wins over stepReq.
    run = 1'b0;
    stepReq = 1'b1;
    cyc(1);
    stepReq = 1'b0;
    chk("abortStep", step, 3'd1);
    chk("abortEn", mosEnable, 3'b000);
    chk("abortSel", h1_L0, 3'b000);
    chk("abortBusy", {2'b00, busy}, 3'b000);
    cyc(3);
    chk("idleHoldStep", step, 3'd1);
    run = 1'b1;
    cyc(21);
    chk("rerunStep", step, 3'd1);
    chk("rerunEn", mosEnable, 3'b101);
    chk("rerunBusy", {2'b00, busy}, 3'b000);

    // Asynchronous reset mid-DRIVE.
    #10;
    nRst = 1'b0;
    #1;
    chk("asyncEn", mosEnable, 3'b000);
    chk("asyncSel", h1_L0, 3'b000);
    chk("asyncStep", step, 3'd0);
    chk("asyncBusy", {2'b00, busy}, 3'b000);
    cyc(1);
    run = 1'b0;
    nRst = 1'b1;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
